// File: rtl/divider_res_buffer_pkg.sv
// Shared defaults and helpers for the divider result buffer.
package divider_res_buffer_pkg;

    // Default geometry; the divider latency equals the dividend width for divider_man.
    localparam int unsigned DefN     = 5;
    localparam int unsigned DefM     = 3;
    localparam int unsigned DefLat   = DefN;
    localparam int unsigned DefDepth = 4;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/divider_res_fifo.sv
// Depth x W synchronous FIFO built from a register array, first-word fall-through.
// A push while full is ignored unless a pop in the same cycle frees the slot.
module divider_res_fifo
    import divider_res_buffer_pkg::*;
#(
    parameter int unsigned W     = 9,
    parameter int unsigned Depth = DefDepth,
    parameter int unsigned CntW  = cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [W-1:0]    wdata_i,
    input  logic            pop_i,
    output logic [W-1:0]    rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [W-1:0]    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state; Depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/divider_res_buffer.sv
// Wrapper around the non-stallable pipelined divider: issues requests as single-cycle
// pulses, tracks divide-by-zero alongside the pipeline, and buffers results in a FIFO.
// Credits (in flight + buffered) never exceed Depth, so a legal result always has room.
module divider_res_buffer
    import divider_res_buffer_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned M     = DefM,
    parameter int unsigned Lat   = DefLat,
    parameter int unsigned Depth = DefDepth
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_dividend_i,
    input  logic [M-1:0] in_divisor_i,
    output logic         div_data_rdy_o,
    output logic [N-1:0] div_dividend_o,
    output logic [M-1:0] div_divisor_o,
    input  logic         div_res_rdy_i,
    input  logic [N-1:0] div_merchant_i,
    input  logic [M-1:0] div_remainder_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_quotient_o,
    output logic [M-1:0] out_remainder_o,
    output logic         out_dz_o,
    output logic         err_o
);

    localparam int unsigned CntW = cnt_width(Depth);
    localparam int unsigned SumW = CntW + 1;
    localparam int unsigned EntW = N + M + 1;

    logic            accept;
    logic            pop;
    logic [SumW-1:0] credit_used;

    logic            data_rdy_q;
    logic [N-1:0]    dividend_q;
    logic [M-1:0]    divisor_q;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [Lat:0]    dz_q, dz_d;
    logic            err_q, err_d;

    logic [EntW-1:0] fifo_wdata;
    logic [EntW-1:0] fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            res_dz;

    // Credit check uses registered state only, so in_ready never depends on in_valid.
    assign credit_used = SumW'(inflight_q) + SumW'(fifo_count);
    assign in_ready_o  = (credit_used < SumW'(Depth));
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign div_data_rdy_o = data_rdy_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;

    // Tail of the dz shift register lines up with div_res_rdy for the same request.
    assign res_dz     = dz_q[Lat];
    assign fifo_wdata = res_dz ? {{N{1'b1}}, {M{1'b0}}, 1'b1}
                               : {div_merchant_i, div_remainder_i, 1'b0};

    // Next-state for the in-flight counter, dz tracker and sticky error.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !div_res_rdy_i) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!accept && div_res_rdy_i && (inflight_q != '0)) begin
            // Guard keeps a spurious res_rdy from wrapping the counter.
            inflight_d = inflight_q - CntW'(1);
        end

        dz_d = {dz_q[Lat-1:0], accept & (in_divisor_i == '0)};

        err_d = err_q;
        if (div_res_rdy_i && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (div_res_rdy_i && fifo_full && !pop) begin
            err_d = 1'b1;
        end
    end

    // Issue register: one data_rdy pulse per accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rdy_q <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            data_rdy_q <= accept;
            if (accept) begin
                dividend_q <= in_dividend_i;
                divisor_q  <= in_divisor_i;
            end
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            dz_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            dz_q       <= dz_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

    divider_res_fifo #(
        .W     (EntW),
        .Depth (Depth),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (div_res_rdy_i),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid_o = ~fifo_empty;
    assign {out_quotient_o, out_remainder_o, out_dz_o} = fifo_rdata;

endmodule

// File: tb/tb_divider_res_buffer.sv
// Bench for divider_res_buffer with a behavioural fixed-latency divider and a
// queue-based reference of outstanding requests.
module tb_divider_res_buffer;

    localparam int unsigned N     = 5;
    localparam int unsigned M     = 3;
    localparam int unsigned Lat   = 5;
    localparam int unsigned Depth = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_dividend;
    logic [M-1:0] in_divisor;
    logic         div_data_rdy;
    logic [N-1:0] div_dividend;
    logic [M-1:0] div_divisor;
    logic         div_res_rdy;
    logic [N-1:0] div_merchant;
    logic [M-1:0] div_remainder;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_quotient;
    logic [M-1:0] out_remainder;
    logic         out_dz;
    logic         err;
    logic         force_rr;

    divider_res_buffer #(
        .N     (N),
        .M     (M),
        .Lat   (Lat),
        .Depth (Depth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_dividend_i   (in_dividend),
        .in_divisor_i    (in_divisor),
        .div_data_rdy_o  (div_data_rdy),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_res_rdy_i   (div_res_rdy),
        .div_merchant_i  (div_merchant),
        .div_remainder_i (div_remainder),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_quotient_o  (out_quotient),
        .out_remainder_o (out_remainder),
        .out_dz_o        (out_dz),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: fixed Lat-cycle pipeline, reset by rst (rstn = ~rst).
    logic [Lat-1:0] pv;
    logic [N-1:0]   pa [Lat];
    logic [M-1:0]   pb [Lat];
    logic [M-1:0]   pb_safe;

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[Lat-2:0], div_data_rdy};
        end
        pa[0] <= div_dividend;
        pb[0] <= div_divisor;
        for (int k = 1; k < Lat; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end

    assign pb_safe      = (pb[Lat-1] == '0) ? M'(1) : pb[Lat-1];
    assign div_res_rdy  = pv[Lat-1] | force_rr;
    // Divide-by-zero returns junk so the override in the buffer is observable.
    assign div_merchant = !pv[Lat-1] ? '0 :
                          (pb[Lat-1] == '0) ? (pa[Lat-1] ^ 5'h0a) : N'(pa[Lat-1] / pb_safe);
    assign div_remainder = !pv[Lat-1] ? '0 :
                           (pb[Lat-1] == '0) ? 3'b101 : M'(pa[Lat-1] % pb_safe);

    typedef struct {
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dz;
        int unsigned  rdy;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  cyc;
    logic         exp_err;
    logic         prev_acc;
    logic [N-1:0] prev_a;
    logic [M-1:0] prev_b;
    int           n_vec;
    int           n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Number of results the model says are sitting in the FIFO right now.
    function automatic int unsigned buffered();
        int unsigned n = 0;
        foreach (exp_q[i]) if (exp_q[i].rdy <= cyc) n++;
        return n;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic tick(input logic v, input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic ordy, input logic frc);
        exp_t e;
        logic exp_rdy, exp_val, popping, acc, full, err_next;
        in_valid    = v;
        in_dividend = a;
        in_divisor  = b;
        out_ready   = ordy;
        force_rr    = frc;
        #1;
        exp_rdy = (exp_q.size() < Depth);
        exp_val = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(exp_val));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("data_rdy", 32'(div_data_rdy), 32'(prev_acc));
        if (prev_acc) begin
            check_eq("div_operands", 32'({div_dividend, div_divisor}), 32'({prev_a, prev_b}));
        end
        popping  = exp_val && ordy;
        acc      = v && exp_rdy;
        full     = (buffered() == Depth);
        err_next = exp_err;
        if (popping && out_valid) begin
            check_eq("head_q", 32'(out_quotient), 32'(exp_q[0].q));
            check_eq("head_r", 32'(out_remainder), 32'(exp_q[0].r));
            check_eq("head_dz", 32'(out_dz), 32'(exp_q[0].dz));
        end
        if (popping) exp_q.pop_front();
        if (frc) begin
            // Forced only when nothing is genuinely in flight.
            err_next = 1'b1;
            if (!full || popping) begin
                e.q = '0; e.r = '0; e.dz = 1'b0; e.rdy = cyc + 1;
                exp_q.push_back(e);
            end
        end
        if (acc) begin
            if (b == '0) begin
                e.q = '1; e.r = '0; e.dz = 1'b1;
            end else begin
                e.q = N'(a / b); e.r = M'(a % b); e.dz = 1'b0;
            end
            e.rdy = cyc + 2 + Lat;
            exp_q.push_back(e);
        end
        prev_acc = acc;
        prev_a   = a;
        prev_b   = b;
        @(posedge clk);
        #1;
        cyc++;
        exp_err = err_next;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        force_rr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc     += 2;
        exp_q.delete();
        exp_err  = 1'b0;
        prev_acc = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, ordy, 1'b0);
    endtask

    int unsigned acc_cyc;
    logic [N-1:0] ops_a [4];
    logic [M-1:0] ops_b [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        ops_a = '{5'd29, 5'd31, 5'd7, 5'd0};
        ops_b = '{3'd5, 3'd3, 3'd2, 3'd1};
        in_dividend = '0;
        in_divisor  = '0;
        @(negedge clk);
        do_reset();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_data_rdy", 32'(div_data_rdy), 32'd0);

        // Single request latency.
        acc_cyc = cyc;
        tick(1'b1, 5'd29, 3'd5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check_eq("latency", cyc - acc_cyc, Lat + 2);
        check_eq("q29_5", 32'(out_quotient), 32'd5);
        check_eq("r29_5", 32'(out_remainder), 32'd4);
        idle(3, 1'b1);

        // Four back-to-back requests fill all credits.
        for (int i = 0; i < 4; i++) tick(1'b1, ops_a[i], ops_b[i], 1'b0, 1'b0);
        check_eq("credit_exhausted", 32'(in_ready), 32'd0);
        idle(10, 1'b0);
        idle(8, 1'b1);
        check_eq("credit_returned", 32'(in_ready), 32'd1);

        // Divide by zero followed by a normal request.
        tick(1'b1, 5'd13, 3'd0, 1'b1, 1'b0);
        tick(1'b1, 5'd29, 3'd5, 1'b1, 1'b0);
        idle(10, 1'b1);

        // Reset with two buffered and two in flight.
        tick(1'b1, 5'd20, 3'd3, 1'b0, 1'b0);
        tick(1'b1, 5'd21, 3'd4, 1'b0, 1'b0);
        idle(8, 1'b0);
        tick(1'b1, 5'd22, 3'd5, 1'b0, 1'b0);
        tick(1'b1, 5'd23, 3'd6, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        do_reset();
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        idle(12, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)), N'($urandom), M'($urandom),
                 ($urandom_range(0, 9) < 7), 1'b0);
        end
        idle(20, 1'b1);

        // Spurious res_rdy while full and not popping: dropped, err sets.
        for (int i = 0; i < 4; i++) tick(1'b1, ops_a[i], ops_b[i], 1'b0, 1'b0);
        idle(10, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("err_set_drop", 32'(err), 32'd1);
        idle(8, 1'b1);
        check_eq("err_sticky", 32'(err), 32'd1);
        do_reset();
        check_eq("err_cleared", 32'(err), 32'd0);

        // Spurious res_rdy while full with a pop: push succeeds, pointers wrap.
        for (int i = 0; i < 4; i++) tick(1'b1, ops_a[i], ops_b[i], 1'b0, 1'b0);
        idle(10, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b1);
        check_eq("full_pushpop_valid", 32'(out_valid), 32'd1);
        idle(8, 1'b1);
        check_eq("err_sticky2", 32'(err), 32'd1);
        do_reset();
        check_eq("err_cleared2", 32'(err), 32'd0);
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
